// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Target end of the RV32I core's data port. It decodes each address into
//   one of three regions:
//     - a byte-writable word RAM with same-cycle (combinational) read data
//     - a 16-byte MMIO window at 0xFFFFFFF0 holding the console transmit
//       FIFO, its status register and a coherent 64-bit cycle counter
//     - everything else, which reads 0 and ignores writes
//
// Parameters
//   MEM_WORDS  RAM depth in 32-bit words (power of two)
//   FIFO_DEPTH console FIFO entries (power of two, >= 2)
//   CNT_INIT   value the cycle counter takes in reset (normally 0)
//
// Ports
//   clk       single clock, rising edge
//   reset     asynchronous, active-low reset
//   daddr     byte address from core (low two bits ignored)
//   dwdata    lane-aligned write data
//   dwe       byte-lane write enables, 0 = read/idle
//   drdata    read data, combinational from daddr
//   tx_data   FIFO head byte, 0 when empty
//   tx_valid  FIFO non-empty
//   tx_ready  console sink takes the head byte this cycle
module dmem_mmio_responder #(
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [63:0] CNT_INIT   = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OFF_TX     = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYC_LO = 2'd2;
  localparam logic [1:0] OFF_CYC_HI = 2'd3;

  logic [31:0]   mem      [MEM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [63:0]   cnt_q, cnt_d;
  logic [31:0]   hi_shadow_q, hi_shadow_d;

  logic          is_ram;
  logic          is_mmio;
  logic [AW-1:0] ram_idx;
  logic [1:0]    mmio_off;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic [31:0]   count_ext;
  logic [3:0]    count_disp;
  logic          unused_addr_lsbs;

  // Byte offset within a word never selects anything.
  assign unused_addr_lsbs = ^daddr[1:0];

  assign is_ram   = (daddr[31:AW+2] == '0);
  assign is_mmio  = (daddr[31:4] == 28'hFFFFFFF);
  assign ram_idx  = daddr[AW+1:2];
  assign mmio_off = daddr[3:2];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  assign tx_valid = !fifo_empty;
  // Stale storage is masked so an empty FIFO always presents 0.
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[head_q];

  assign pop      = tx_valid && tx_ready;
  assign push_req = is_mmio && (mmio_off == OFF_TX) && dwe[0];
  // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
  assign push_ok  = push_req && (!fifo_full || pop);

  // STATUS only has a 4-bit count field; deeper FIFOs saturate the display.
  assign count_ext  = 32'(count_q);
  assign count_disp = (count_ext > 32'd15) ? 4'd15 : count_ext[3:0];

  always_comb begin
    drdata = 32'h0;
    if (is_ram) begin
      drdata = mem[ram_idx];
    end else if (is_mmio) begin
      case (mmio_off)
        OFF_STATUS: drdata = {24'h0, count_disp, 1'b0, ovf_q, fifo_full, fifo_empty};
        OFF_CYC_LO: drdata = cnt_q[31:0];
        OFF_CYC_HI: drdata = hi_shadow_q;
        default:    drdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q + 64'd1;
    hi_shadow_d = hi_shadow_q;

    if (pop)     head_d = head_q + PW'(1);
    if (push_ok) tail_d = tail_q + PW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) ovf_d = 1'b1;
    if (is_mmio && (mmio_off == OFF_STATUS) && dwe[0] && dwdata[2]) ovf_d = 1'b0;

    // Reading the low half freezes the high half so a LO-then-HI pair is
    // coherent even if the counter carries between the two reads.
    if (is_mmio && (mmio_off == OFF_CYC_LO) && (dwe == 4'h0)) hi_shadow_d = cnt_q[63:32];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= CNT_INIT;
      hi_shadow_q <= 32'h0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  // Storage arrays carry no reset: RAM survives reset, and FIFO slots are
  // only observable through the reset-cleared pointers.
  always_ff @(posedge clk) begin
    if (is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (dwe[b]) mem[ram_idx][8*b +: 8] <= dwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[tail_q] <= dwdata[7:0];
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_TX   = 32'hFFFF_FFF0;
  localparam logic [31:0] A_ST   = 32'hFFFF_FFF4;
  localparam logic [31:0] A_LO   = 32'hFFFF_FFF8;
  localparam logic [31:0] A_HI   = 32'hFFFF_FFFC;
  localparam logic [31:0] A_IDLE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dwe;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;

  logic        reset2;
  logic [31:0] daddr2, drdata2;
  logic [7:0]  tx_data2;
  logic        tx_valid2;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];
  logic [31:0] r;

  always #5 clk = ~clk;

  dmem_mmio_responder u_dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // Counter preloaded just below the 32-bit carry.
  dmem_mmio_responder #(.CNT_INIT(64'h0000_0000_FFFF_FFF0)) u_cnt (
    .clk(clk), .reset(reset2), .daddr(daddr2), .dwdata(32'h0), .dwe(4'h0),
    .drdata(drdata2), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr = a; dwdata = d; dwe = we;
    @(posedge clk); #1;
    dwe = 4'h0; daddr = A_IDLE;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    daddr = a; dwe = 4'h0;
    @(negedge clk);
    d = drdata;
    @(posedge clk); #1;
    daddr = A_IDLE;
  endtask

  task automatic tx_push(input logic [7:0] b, input bit keep);
    if (keep) sb_q.push_back(b);
    wr(A_TX, {24'h0, b}, 4'b0001);
  endtask

  // Scoreboard: every accepted handshake must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      if (sb_q.size() == 0) chk("tx_extra_valid", tx_valid, 1'b0);
      else                  chk("tx_data", tx_data, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    daddr = A_ST; dwdata = 32'h0; dwe = 4'h0; tx_ready = 1'b0; daddr2 = A_LO;
    #2 reset = 1'b0; reset2 = 1'b0;
    #10;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_status", drdata, 32'h1);
    daddr = A_LO; #1 chk("rst_lo", drdata, 32'h0);
    daddr = A_HI; #1 chk("rst_hi", drdata, 32'h0);

    @(posedge clk); #1;
    reset = 1'b1; daddr = A_LO;
    @(negedge clk); chk("cnt_start", drdata, 32'd0);
    @(negedge clk); chk("cnt_one", drdata, 32'd1);
    @(posedge clk); #1 daddr = A_IDLE;

    // RAM byte lanes
    wr(32'h10, 32'hAABBCCDD, 4'b1111);
    rd(32'h10, r); chk("ram_full", r, 32'hAABBCCDD);
    wr(32'h10, 32'h00000011, 4'b0001);
    rd(32'h10, r); chk("ram_lane0", r, 32'hAABBCC11);
    wr(32'h10, 32'h12340000, 4'b1100);
    rd(32'h10, r); chk("ram_lane32", r, 32'h1234CC11);
    rd(32'h12, r); chk("ram_unaligned", r, 32'h1234CC11);

    // Same-cycle read and write returns old data
    wr(32'h20, 32'h01020304, 4'b1111);
    daddr = 32'h20; dwdata = 32'h55667788; dwe = 4'b1111;
    @(negedge clk); chk("ram_rdw_old", drdata, 32'h01020304);
    @(posedge clk); #1 dwe = 4'h0;
    rd(32'h20, r); chk("ram_rdw_new", r, 32'h55667788);

    // Unmapped and RAM boundary
    wr(A_IDLE, 32'hDEADBEEF, 4'b1111);
    rd(32'h10, r); chk("unmapped_wr", r, 32'h1234CC11);
    rd(A_IDLE, r); chk("unmapped_rd", r, 32'h0);
    wr(32'h0, 32'hCAFE0000, 4'b1111);
    wr(32'hFFC, 32'h600DD00D, 4'b1111);
    rd(32'hFFC, r); chk("ram_last", r, 32'h600DD00D);
    wr(32'h1000, 32'h12121212, 4'b1111);
    rd(32'h0, r); chk("ram_no_alias", r, 32'hCAFE0000);
    rd(32'h1000, r); chk("ram_past_end", r, 32'h0);

    // FIFO order and handshake
    tx_ready = 1'b0;
    tx_push(8'h41, 1); tx_push(8'h42, 1); tx_push(8'h43, 1);
    chk("head_valid", tx_valid, 1'b1);
    chk("head_data", tx_data, 8'h41);
    rd(A_TX, r); chk("tx_reads_zero", r, 32'h0);
    rd(A_ST, r); chk("status_cnt3", r, 32'h30);
    chk("hold_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_ready = 1'b0;
    chk("drain3_left", sb_q.size(), 0);
    chk("drain3_valid", tx_valid, 1'b0);
    chk("drain3_data", tx_data, 8'h00);
    rd(A_ST, r); chk("status_empty", r, 32'h1);

    // Overflow, full push+pop, clear
    for (int i = 0; i < 9; i++) tx_push(8'h50 + 8'(i), i < 8);
    rd(A_ST, r); chk("status_ovf_full", r, 32'h86);
    tx_ready = 1'b1;
    tx_push(8'h59, 1);
    tx_ready = 1'b0;
    rd(A_ST, r); chk("status_pushpop", r, 32'h86);
    wr(A_ST, 32'h4, 4'b0001);
    rd(A_ST, r); chk("status_ovf_clr", r, 32'h82);
    tx_ready = 1'b1;
    for (int k = 0; k < 30 && sb_q.size() != 0; k++) @(posedge clk);
    #1 tx_ready = 1'b0;
    chk("drain_ovf_left", sb_q.size(), 0);
    chk("drain_ovf_valid", tx_valid, 1'b0);

    // Async reset mid-drain
    tx_push(8'h61, 1); tx_push(8'h62, 1); tx_push(8'h63, 1);
    chk("pre_rst_valid", tx_valid, 1'b1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_valid", tx_valid, 1'b0);
    chk("async_data", tx_data, 8'h00);
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b1; daddr = A_LO;
    @(negedge clk); chk("cnt_restart", drdata, 32'd0);
    @(posedge clk); #1;
    rd(A_ST, r);   chk("post_rst_status", r, 32'h1);
    rd(32'h10, r); chk("ram_retained", r, 32'h1234CC11);
    rd(A_HI, r);   chk("post_rst_hi", r, 32'h0);

    // Counter coherence across the 32-bit carry
    @(posedge clk); #1;
    reset2 = 1'b1; daddr2 = A_LO;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (drdata2 == 32'hFFFF_FFFF) break;
    end
    chk("lo_ffff", drdata2, 32'hFFFF_FFFF);
    @(posedge clk); #1 daddr2 = A_HI;
    @(negedge clk); chk("hi_coherent", drdata2, 32'h0);
    @(posedge clk); #1 daddr2 = A_LO;
    @(negedge clk); chk("lo_wrapped", drdata2, 32'h1);
    @(posedge clk); #1 daddr2 = A_HI;
    @(negedge clk); chk("hi_fresh", drdata2, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Data-memory responder for the single-cycle RV32I core: the target end of its data port (daddr/dwdata/dwe out, drdata in). Serves a byte-writable word RAM with same-cycle read data, and a small MMIO window holding a console transmit FIFO with a valid/ready drain port and a coherent 64-bit cycle counter. It sits beside the core in the top level and feeds the console sink.

## Interface
- MEM_WORDS, 1024: RAM depth in 32-bit words; power of two; RAM occupies byte addresses 0 .. 4*MEM_WORDS-1.
- FIFO_DEPTH, 8: console FIFO entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- daddr  in  32  byte address from core.
- dwdata  in  32  write data, lane-aligned.
- dwe  in  4  byte-lane write enables; 0 = read/idle.
- drdata  out  32  read data, combinational from daddr.
- tx_data  out  8  FIFO head byte; 0 when empty.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  console sink accepts head this cycle.

## Operation
- Decode: RAM if daddr < 4*MEM_WORDS; MMIO if daddr[31:4] == 28'hFFFFFFF; else unmapped (read 0, writes ignored). Low two address bits are ignored for all word selection.
- RAM read: drdata = mem[daddr[log2(MEM_WORDS)+1:2]], full aligned word; the core does lane extraction and extension.
- RAM write: at posedge, for each b with dwe[b]=1, mem[idx][8b+7:8b] <= dwdata[8b+7:8b]; other lanes unchanged. RAM not reset.
- MMIO offsets (daddr[3:2]):
  - 0 CONSOLE_TX: write with dwe[0]=1 pushes dwdata[7:0]; reads 0.
  - 1 STATUS: read {24'b0, count[3:0], 1'b0, ovf, full, empty}; count saturates display at 15. Write with dwe[0]=1 and dwdata[2]=1 clears ovf.
  - 2 CYCLE_LO: read returns cnt[31:0]; a read event also latches cnt[63:32] into hi_shadow.
  - 3 CYCLE_HI: read returns hi_shadow.
- Read event = posedge with the given daddr and dwe == 0.
- FIFO: circular, FIFO_DEPTH entries, head/tail pointers plus occupancy count (0..FIFO_DEPTH).
  - push when full and no pop that cycle: byte dropped, ovf <= 1 (sticky).
  - pop when tx_valid && tx_ready.
  - push and pop same cycle: both act, count unchanged, no overflow even if full.
  - pointers wrap modulo FIFO_DEPTH.
- cnt: 64-bit, increments every cycle out of reset, wraps 2^64-1 -> 0.
- Reset assertion (reset=0): FIFO flushed (count 0, pointers 0), ovf 0, cnt 0, hi_shadow 0, tx_valid 0 immediately. A byte with tx_valid high is discarded. RAM contents preserved.

## Timing
- Reset values: tx_valid 0, tx_data 0, drdata reflects current daddr (MMIO reads show reset state; RAM reads undefined until written).
- drdata is zero-latency combinational; meets the core's single-cycle load.
- RAM write at edge N: read of same word after edge N returns new data. Read and write to the same word in one cycle returns old data.
- Console push at edge N: tx_valid=1, tx_data valid after edge N, not before.
- Pop: head advances at the edge where tx_valid && tx_ready. tx_data/tx_valid are stable while tx_valid && !tx_ready.
- STATUS and cnt reads show pre-edge values. A CYCLE_LO read at edge N makes hi_shadow valid from N.
- Release of reset: the first count increment is on the first posedge with reset=1.

## Test plan
- RAM lanes: write 0xAABBCCDD to 0x10 with dwe=1111, then 0x00000011 with dwe=0001 -> read 0x10 gives 0xAABBCC11. Write dwe=1100 data 0x12340000 -> 0x1234CC11. Read 0x12 gives the same word.
- Unmapped: write to 0x00010000 -> no RAM change. Read gives 0.
- FIFO order/handshake: tx_ready=0, push 0x41,0x42,0x43 -> STATUS count=3. Raise tx_ready -> tx_data 0x41,0x42,0x43 on three consecutive cycles, then tx_valid=0 and STATUS empty=1.
- Overflow/full: tx_ready=0, push 9 bytes (depth 8) -> full=1, ovf=1, 9th byte absent on drain. With full, push and pop in the same cycle -> count stays 8, ovf unchanged. Write STATUS with 0x4 -> ovf=0.
- Counter coherence: force cnt=0x00000000_FFFFFFFF, read LO at that edge -> 0xFFFFFFFF, then read HI -> 0x00000000 despite the wrap. A fresh LO read followed by HI -> 1.
- Async reset mid-drain: 3 bytes queued, tx_valid=1, pull reset low between edges -> tx_valid falls without a clock, STATUS empty=1 after release, cnt restarts from 0, RAM word 0x10 retains its value.
